// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller:
// reset PC, FSM state encoding and the NOP word used for empty/faulting slots.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_IDLE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_pcadder.sv
// Sequential next-PC adder: PC + 4, wrapping modulo 2^32.
module fetch_ctrl_pcadder (
  input  logic [31:0] pc,
  output logic [31:0] pc_next
);

  assign pc_next = pc + 32'd4;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues one SRAM-style
// request at a time, and hands fetched words to decode through a single
// output slot. Redirects that race an outstanding transaction set a cancel
// flag so that the stale response is dropped before the new fetch starts.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_flush,
  input  logic [31:0] exc_pc,
  input  logic        id_allowin,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  logic [31:0]  pc_plus4;
  logic         cancel;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         consumed;
  logic         slot_free;
  logic         misaligned;

  fetch_ctrl_pcadder u_pcadder (
    .pc      (fetch_pc),
    .pc_next (pc_plus4)
  );

  assign redirect    = exc_flush | br_taken;
  assign redirect_pc = exc_flush ? exc_pc : br_target;
  assign consumed    = if_valid & id_allowin;
  assign slot_free   = ~if_valid | id_allowin;
  assign misaligned  = |fetch_pc[1:0];
  assign inst_addr   = fetch_pc;

  // A request goes out only when nothing stale is in flight and the slot can take the reply.
  always_comb begin
    inst_req = 1'b0;
    if (!rst && state == S_REQ && !cancel && !misaligned && slot_free)
      inst_req = 1'b1;
  end

  // Fetch FSM, PC, cancel flag and output slot; redirects override everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      cancel   <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= RESET_PC;
      if_inst  <= NOP;
      if_adel  <= 1'b0;
    end else if (redirect) begin
      state    <= S_REQ;
      fetch_pc <= redirect_pc;
      if_valid <= 1'b0;
      if_adel  <= 1'b0;
      cancel   <= (cancel && !inst_data_ok)
                | (state == S_WAIT && !inst_data_ok)
                | (inst_req && inst_addr_ok);
    end else if (cancel) begin
      if (inst_data_ok)
        cancel <= 1'b0;
      if (consumed)
        if_valid <= 1'b0;
    end else begin
      if (consumed)
        if_valid <= 1'b0;
      case (state)
        S_REQ: begin
          if (misaligned) begin
            if (slot_free) begin
              if_valid <= 1'b1;
              if_pc    <= fetch_pc;
              if_inst  <= NOP;
              if_adel  <= 1'b1;
              state    <= S_IDLE;
            end
          end else if (inst_req && inst_addr_ok) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            if_valid <= 1'b1;
            if_pc    <= fetch_pc;
            if_inst  <= inst_rdata;
            if_adel  <= 1'b0;
            fetch_pc <= pc_plus4;
            state    <= slot_free ? S_REQ : S_IDLE;
          end
        end
        S_IDLE: begin
          if (consumed && !misaligned)
            state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: walks a hand-timed sequence of
// fetches, stalls, redirects, an address-error fetch and a mid-flight reset.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_flush;
  logic [31:0] exc_pc;
  logic        id_allowin;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  int compared;
  int mismatched;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .exc_flush    (exc_flush),
    .exc_pc       (exc_pc),
    .id_allowin   (id_allowin),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_adel      (if_adel)
  );

  // Free-running 10-unit core clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs just after the clock edge and let outputs settle.
  task automatic applyStimulus(input logic aok, input logic dok, input logic [31:0] rdata,
                               input logic br, input logic [31:0] bt,
                               input logic exc, input logic [31:0] ep, input logic allow);
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rdata;
    br_taken     = br;
    br_target    = bt;
    exc_flush    = exc;
    exc_pc       = ep;
    id_allowin   = allow;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    #2;
    checkOutput("rst_req",   32'(inst_req), 32'd0);
    checkOutput("rst_addr",  inst_addr,     RESET_PC);
    checkOutput("rst_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_pc",    if_pc,         RESET_PC);
    checkOutput("rst_inst",  if_inst,       32'h0);
    checkOutput("rst_adel",  32'(if_adel),  32'd0);
    tick();
    tick();
    rst = 1'b0;

    // First fetch: addr_ok one cycle after the first request, data_ok one cycle later.
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("first_req",  32'(inst_req), 32'd1);
    checkOutput("first_addr", inst_addr,     32'hBFC0_0000);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("first_req_held", 32'(inst_req), 32'd1);
    tick();
    applyStimulus(0, 1, 32'h2408_0001, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("wait_no_req", 32'(inst_req), 32'd0);
    tick();

    // Delivery followed by five cycles of decode back-pressure.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
      checkOutput("stall_valid", 32'(if_valid), 32'd1);
      checkOutput("stall_pc",    if_pc,         32'hBFC0_0000);
      checkOutput("stall_inst",  if_inst,       32'h2408_0001);
      checkOutput("stall_req",   32'(inst_req), 32'd0);
      checkOutput("stall_addr",  inst_addr,     32'hBFC0_0004);
      tick();
    end
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("release_req", 32'(inst_req), 32'd1);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("release_valid", 32'(if_valid), 32'd0);
    checkOutput("release_addr",  inst_addr,     32'hBFC0_0004);
    tick();

    // Branch while waiting for data: the in-flight response must be dropped.
    applyStimulus(0, 0, 32'h0, 1, 32'hBFC0_0100, 0, 32'h0, 1);
    tick();
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("cancel_req",   32'(inst_req), 32'd0);
    checkOutput("cancel_addr",  inst_addr,     32'hBFC0_0100);
    checkOutput("cancel_valid", 32'(if_valid), 32'd0);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("br_req",       32'(inst_req), 32'd1);
    checkOutput("br_addr",      inst_addr,     32'hBFC0_0100);
    checkOutput("discard_valid",32'(if_valid), 32'd0);
    tick();
    applyStimulus(0, 1, 32'h1111_1111, 0, 32'h0, 0, 32'h0, 1);
    tick();

    // Branch and exception in the same cycle: the exception vector wins.
    applyStimulus(0, 0, 32'h0, 1, 32'hBFC0_0200, 1, 32'hBFC0_0380, 1);
    checkOutput("br_deliv_pc",   if_pc,   32'hBFC0_0100);
    checkOutput("br_deliv_inst", if_inst, 32'h1111_1111);
    checkOutput("br_next_addr",  inst_addr, 32'hBFC0_0104);
    tick();

    // Address acceptance held off for four cycles: request must stay frozen.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
      checkOutput("exc_req",   32'(inst_req), 32'd1);
      checkOutput("exc_addr",  inst_addr,     32'hBFC0_0380);
      checkOutput("exc_valid", 32'(if_valid), 32'd0);
      tick();
    end
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    tick();
    applyStimulus(0, 1, 32'h3333_3333, 0, 32'h0, 0, 32'h0, 1);
    tick();

    // Branch to a misaligned target: no bus request, address-error slot instead.
    applyStimulus(0, 0, 32'h0, 1, 32'hBFC0_0102, 0, 32'h0, 1);
    checkOutput("exc_deliv_pc",   if_pc,     32'hBFC0_0380);
    checkOutput("exc_deliv_inst", if_inst,   32'h3333_3333);
    checkOutput("exc_next_addr",  inst_addr, 32'hBFC0_0384);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("adel_no_req", 32'(inst_req), 32'd0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("adel_valid", 32'(if_valid), 32'd1);
    checkOutput("adel_flag",  32'(if_adel),  32'd1);
    checkOutput("adel_pc",    if_pc,         32'hBFC0_0102);
    checkOutput("adel_inst",  if_inst,       32'h0);
    checkOutput("adel_req",   32'(inst_req), 32'd0);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 32'hBFC0_0380, 1);
    checkOutput("adel_hold_req", 32'(inst_req), 32'd0);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("flush_req",  32'(inst_req), 32'd1);
    checkOutput("flush_addr", inst_addr,     32'hBFC0_0380);
    checkOutput("flush_adel", 32'(if_adel),  32'd0);
    tick();

    // Reset asserted while a response is outstanding.
    rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("midrst_req",   32'(inst_req), 32'd0);
    checkOutput("midrst_addr",  inst_addr,     RESET_PC);
    checkOutput("midrst_valid", 32'(if_valid), 32'd0);
    checkOutput("midrst_pc",    if_pc,         RESET_PC);
    checkOutput("midrst_inst",  if_inst,       32'h0);
    tick();
    rst = 1'b0;
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("rerst_req",  32'(inst_req), 32'd1);
    checkOutput("rerst_addr", inst_addr,     RESET_PC);
    tick();
    applyStimulus(0, 1, 32'h4444_4444, 0, 32'h0, 0, 32'h0, 1);
    tick();

    // Redirect to the last word of the address space to exercise +4 wrap.
    applyStimulus(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1);
    checkOutput("rerst_valid", 32'(if_valid), 32'd1);
    checkOutput("rerst_pc",    if_pc,         32'hBFC0_0000);
    checkOutput("rerst_inst",  if_inst,       32'h4444_4444);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("wrap_addr", inst_addr, 32'hFFFF_FFFC);
    tick();
    applyStimulus(0, 1, 32'h5555_5555, 0, 32'h0, 0, 32'h0, 1);
    tick();

    // Redirect in the same cycle the request is accepted: that response is cancelled.
    applyStimulus(1, 0, 32'h0, 1, 32'hBFC0_0010, 0, 32'h0, 1);
    checkOutput("wrap_pc",   if_pc,         32'hFFFF_FFFC);
    checkOutput("wrap_next", inst_addr,     32'h0000_0000);
    checkOutput("wrap_req",  32'(inst_req), 32'd1);
    tick();
    applyStimulus(0, 1, 32'hBAD0_BAD0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("acc_cancel_req",  32'(inst_req), 32'd0);
    checkOutput("acc_cancel_addr", inst_addr,     32'hBFC0_0010);
    tick();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("acc_refetch_req",   32'(inst_req), 32'd1);
    checkOutput("acc_refetch_valid", 32'(if_valid), 32'd0);
    tick();
    applyStimulus(0, 1, 32'h6666_6666, 0, 32'h0, 0, 32'h0, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("acc_valid", 32'(if_valid), 32'd1);
    checkOutput("acc_pc",    if_pc,         32'hBFC0_0010);
    checkOutput("acc_inst",  if_inst,       32'h6666_6666);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
